// File: rtl/wb_arb.sv
// Writeback arbiter: merges the ALU result stream and a buffered long-latency stream onto the register-file write port.
// Latency: one cycle from the selected source to d/rd/wr; a long-latency entry reaches wr no earlier than 2 cycles after its push.
// Backpressure: ALU is never stalled per cycle; ext_ready = !full; stall asks upstream to idle the ALU so a starved FIFO head can drain.
// Optional: define WB_BYPASS_EN to add the regfile read bypass ports (byp_*).
module wb_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] alu_d,
  input  logic [4:0]  alu_rd,
  input  logic        alu_wr,
  input  logic [63:0] ext_d,
  input  logic [4:0]  ext_rd,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic [4:0]  iss_rd,
  input  logic        iss_set,
  output logic [31:0] pend,
  output logic        stall,
`ifdef WB_BYPASS_EN
  input  logic [4:0]  byp_rs1,
  input  logic [4:0]  byp_rs2,
  input  logic [63:0] byp_r1_in,
  input  logic [63:0] byp_r2_in,
  output logic [63:0] byp_r1,
  output logic [63:0] byp_r2,
`endif
  output logic [63:0] d,
  output logic [4:0]  rd,
  output logic        wr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  logic [63:0]   mem_d  [DEPTH];
  logic [4:0]    mem_rd [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [3:0]    starve;
  logic [31:0]   pend_nxt;

  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        alu_sel;
  logic [63:0] head_d;
  logic [4:0]  head_rd;

  // Ready comes from the registered count only, so a pop never opens the FIFO in the same cycle.
  assign fifo_empty = (count == '0);
  assign ext_ready  = (count != FULL_CNT);
  assign stall      = (starve == STARVE_LIM) && !fifo_empty;
  assign push       = ext_valid && ext_ready;
  // A starving head beats the ALU; an ALU write to x0 is ignored and never blocks the FIFO.
  assign alu_sel    = alu_wr && (alu_rd != 5'd0) && !stall;
  assign pop        = !fifo_empty && !alu_sel;
  assign head_d     = mem_d[rptr];
  assign head_rd    = mem_rd[rptr];

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wptr]  <= ext_d;
      mem_rd[wptr] <= ext_rd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Register-file write port; d/rd hold whenever nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= 1'b0;
      d  <= '0;
      rd <= '0;
    end else if (alu_sel) begin
      wr <= 1'b1;
      d  <= alu_d;
      rd <= alu_rd;
    end else if (pop && (head_rd != 5'd0)) begin
      wr <= 1'b1;
      d  <= head_d;
      rd <= head_rd;
    end else begin
      wr <= 1'b0;
    end
  end

  // Pending bitmap next state: pop clears, issue sets afterwards so a same-cycle set wins.
  always_comb begin
    pend_nxt = pend;
    if (pop)     pend_nxt[head_rd] = 1'b0;
    if (iss_set) pend_nxt[iss_rd]  = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Pending bitmap register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  // Starvation counter: counts ALU wins over a waiting head, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (fifo_empty || pop) begin
      starve <= '0;
    end else if (starve != STARVE_LIM) begin
      starve <= starve + 4'd1;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write in flight when the regfile would still return the old value.
  always_comb begin
    byp_r1 = byp_r1_in;
    byp_r2 = byp_r2_in;
    if (wr && (rd == byp_rs1) && (byp_rs1 != 5'd0)) byp_r1 = d;
    if (wr && (rd == byp_rs2) && (byp_rs2 != 5'd0)) byp_r2 = d;
  end
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: vector table, directed multi-cycle sequences, and a randomized run
// against a queue-based reference model. Inputs change 1 time unit after posedge; outputs are read there too.
module tb_wb_arb;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic [63:0] alu_d;
  logic [4:0]  alu_rd;
  logic        alu_wr;
  logic [63:0] ext_d;
  logic [4:0]  ext_rd;
  logic        ext_valid;
  logic        ext_ready;
  logic [4:0]  iss_rd;
  logic        iss_set;
  logic [31:0] pend;
  logic        stall;
  logic [63:0] d;
  logic [4:0]  rd;
  logic        wr;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_rs1;
  logic [4:0]  byp_rs2;
  logic [63:0] byp_r1_in;
  logic [63:0] byp_r2_in;
  logic [63:0] byp_r1;
  logic [63:0] byp_r2;
`endif

  int n_chk;
  int n_fail;

  wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_d     (alu_d),
    .alu_rd    (alu_rd),
    .alu_wr    (alu_wr),
    .ext_d     (ext_d),
    .ext_rd    (ext_rd),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .iss_rd    (iss_rd),
    .iss_set   (iss_set),
    .pend      (pend),
    .stall     (stall),
`ifdef WB_BYPASS_EN
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp_r1_in (byp_r1_in),
    .byp_r2_in (byp_r2_in),
    .byp_r1    (byp_r1),
    .byp_r2    (byp_r2),
`endif
    .d         (d),
    .rd        (rd),
    .wr        (wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream contract: the ALU must be idle whenever stall is raised.
  always @(negedge clk) begin
    if (!rst && stall && alu_wr) begin
      n_fail++;
      $display("FAIL contract_stall_alu: alu_wr=%0b while stall=%0b, required alu_wr=0", alu_wr, stall);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_wr = 1'b0; alu_rd = '0; alu_d = '0;
    ext_valid = 1'b0; ext_rd = '0; ext_d = '0;
    iss_set = 1'b0; iss_rd = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        a_wr;
    logic [4:0]  a_rd;
    logic [63:0] a_d;
    logic        i_set;
    logic [4:0]  i_rd;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [63:0] e_d;
    logic [31:0] e_pend;
  } vec_t;

  typedef struct {
    logic [63:0] dat;
    logic [4:0]  r;
  } ent_t;

  vec_t tbl [8];

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pend;
  int          m_starve;
  logic        m_wr;
  logic [63:0] m_d;
  logic [4:0]  m_rd;

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle();
`ifdef WB_BYPASS_EN
    byp_rs1 = '0; byp_rs2 = '0; byp_r1_in = '0; byp_r2_in = '0;
`endif
    rst = 1'b1;
    #3;
    chk("reset_wr", {63'd0, wr}, 64'd0);
    chk("reset_d", d, 64'd0);
    chk("reset_rd", {59'd0, rd}, 64'd0);
    chk("reset_ready", {63'd0, ext_ready}, 64'd1);
    chk("reset_pend", {32'd0, pend}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    cyc();
    rst = 1'b0;

    // ---------------- table: ALU writes and pending sets, FIFO idle ----------------
    tbl[0] = '{1'b1, 5'd5,  64'h1234,             1'b0, 5'd0,  1'b1, 5'd5,  64'h1234,             32'h0000_0000};
    tbl[1] = '{1'b1, 5'd0,  64'hDEAD,             1'b0, 5'd0,  1'b0, 5'd5,  64'h1234,             32'h0000_0000};
    tbl[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd9, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0200};
    tbl[3] = '{1'b0, 5'd4,  64'h7777,             1'b1, 5'd0,  1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0200};
    tbl[4] = '{1'b1, 5'd1,  64'h1,                1'b1, 5'd31, 1'b1, 5'd1,  64'h1,                32'h8000_0200};
    tbl[5] = '{1'b0, 5'd0,  64'h0,                1'b0, 5'd0,  1'b0, 5'd1,  64'h1,                32'h8000_0200};
    tbl[6] = '{1'b1, 5'd17, 64'hCAFE,             1'b1, 5'd17, 1'b1, 5'd17, 64'hCAFE,             32'h8002_0200};
    tbl[7] = '{1'b1, 5'd5,  64'h0,                1'b0, 5'd0,  1'b1, 5'd5,  64'h0,                32'h8002_0200};
    for (int i = 0; i < 8; i++) begin
      alu_wr = tbl[i].a_wr; alu_rd = tbl[i].a_rd; alu_d = tbl[i].a_d;
      iss_set = tbl[i].i_set; iss_rd = tbl[i].i_rd;
      cyc();
      chk($sformatf("tbl%0d_wr", i), {63'd0, wr}, {63'd0, tbl[i].e_wr});
      chk($sformatf("tbl%0d_rd", i), {59'd0, rd}, {59'd0, tbl[i].e_rd});
      chk($sformatf("tbl%0d_d", i), d, tbl[i].e_d);
      chk($sformatf("tbl%0d_pend", i), {32'd0, pend}, {32'd0, tbl[i].e_pend});
    end

    // ---------------- arbitration: ext entry with ALU idle ----------------
    do_reset();
    iss_set = 1'b1; iss_rd = 5'd7;
    cyc();
    iss_set = 1'b0;
    ext_valid = 1'b1; ext_rd = 5'd7; ext_d = 64'hAA;
    cyc();
    ext_valid = 1'b0;
    chk("arb_wr_n1", {63'd0, wr}, 64'd0);
    chk("arb_pend7_n1", {63'd0, pend[7]}, 64'd1);
    cyc();
    chk("arb_wr_n2", {63'd0, wr}, 64'd1);
    chk("arb_rd_n2", {59'd0, rd}, 64'd7);
    chk("arb_d_n2", d, 64'hAA);
    chk("arb_pend7_n2", {63'd0, pend[7]}, 64'd0);

    // ---------------- starvation: ALU busy, head wins after STARVE_MAX losses ----------------
    do_reset();
    ext_valid = 1'b1; ext_rd = 5'd8; ext_d = 64'hBB;
    alu_wr = 1'b1; alu_rd = 5'd1; alu_d = 64'd100;
    cyc();
    ext_valid = 1'b0;
    for (int k = 0; k < STARVE_MAX; k++) begin
      chk($sformatf("starve_nostall%0d", k), {63'd0, stall}, 64'd0);
      alu_wr = 1'b1; alu_rd = 5'(10 + k); alu_d = 64'(200 + k);
      cyc();
      chk($sformatf("starve_alu_rd%0d", k), {59'd0, rd}, 64'(10 + k));
      chk($sformatf("starve_alu_wr%0d", k), {63'd0, wr}, 64'd1);
    end
    chk("starve_stall", {63'd0, stall}, 64'd1);
    alu_wr = 1'b0;
    cyc();
    chk("starve_ext_wr", {63'd0, wr}, 64'd1);
    chk("starve_ext_rd", {59'd0, rd}, 64'd8);
    chk("starve_ext_d", d, 64'hBB);
    chk("starve_stall_clr", {63'd0, stall}, 64'd0);

    // ---------------- backpressure: fill, hold third offer, drain in order ----------------
    do_reset();
    alu_wr = 1'b1; alu_rd = 5'd1; alu_d = 64'd1;
    ext_valid = 1'b1; ext_rd = 5'd11; ext_d = 64'hA1;
    chk("bp_ready_a", {63'd0, ext_ready}, 64'd1);
    cyc();
    ext_rd = 5'd12; ext_d = 64'hA2;
    chk("bp_ready_b", {63'd0, ext_ready}, 64'd1);
    cyc();
    ext_rd = 5'd13; ext_d = 64'hA3;
    chk("bp_full", {63'd0, ext_ready}, 64'd0);
    for (int k = 0; k < 12 && !stall; k++) begin
      cyc();
      chk("bp_held", {63'd0, ext_ready}, 64'd0);
    end
    chk("bp_stall", {63'd0, stall}, 64'd1);
    alu_wr = 1'b0;
    cyc();
    chk("bp_ready_after_pop", {63'd0, ext_ready}, 64'd1);
    chk("bp_w1", {58'd0, wr, rd}, {58'd0, 1'b1, 5'd11});
    chk("bp_d1", d, 64'hA1);
    cyc();
    ext_valid = 1'b0;
    chk("bp_w2", {58'd0, wr, rd}, {58'd0, 1'b1, 5'd12});
    chk("bp_d2", d, 64'hA2);
    cyc();
    chk("bp_w3", {58'd0, wr, rd}, {58'd0, 1'b1, 5'd13});
    chk("bp_d3", d, 64'hA3);
    cyc();
    chk("bp_idle", {63'd0, wr}, 64'd0);

    // ---------------- pending: set wins over same-cycle clear; x0 never pends ----------------
    do_reset();
    iss_set = 1'b1; iss_rd = 5'd9;
    cyc();
    iss_set = 1'b0;
    chk("pend9_set", {63'd0, pend[9]}, 64'd1);
    cyc();
    ext_valid = 1'b1; ext_rd = 5'd9; ext_d = 64'h99;
    cyc();
    ext_valid = 1'b0;
    iss_set = 1'b1; iss_rd = 5'd9;
    cyc();
    iss_set = 1'b0;
    chk("pend9_pop_wr", {58'd0, wr, rd}, {58'd0, 1'b1, 5'd9});
    chk("pend9_kept", {32'd0, pend}, 64'h200);
    iss_set = 1'b1; iss_rd = 5'd0;
    cyc();
    iss_set = 1'b0;
    chk("pend_x0", {32'd0, pend}, 64'h200);

    // ---------------- reset mid-stream with two entries queued ----------------
    do_reset();
    iss_set = 1'b1; iss_rd = 5'd4;
    alu_wr = 1'b1; alu_rd = 5'd2; alu_d = 64'h22;
    ext_valid = 1'b1; ext_rd = 5'd21; ext_d = 64'h2100;
    cyc();
    iss_set = 1'b0;
    alu_rd = 5'd3; ext_rd = 5'd22; ext_d = 64'h2200;
    cyc();
    idle();
    chk("rstmid_pre_full", {63'd0, ext_ready}, 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_wr", {63'd0, wr}, 64'd0);
    chk("rstmid_pend", {32'd0, pend}, 64'd0);
    chk("rstmid_ready", {63'd0, ext_ready}, 64'd1);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rstmid_nowr%0d", k), {63'd0, wr}, 64'd0);
    end

`ifdef WB_BYPASS_EN
    // ---------------- bypass ----------------
    alu_wr = 1'b1; alu_rd = 5'd3; alu_d = 64'h55;
    cyc();
    alu_wr = 1'b0;
    byp_rs1 = 5'd3; byp_r1_in = 64'h11;
    byp_rs2 = 5'd4; byp_r2_in = 64'h22;
    #1;
    chk("byp_r1_hit", byp_r1, 64'h55);
    chk("byp_r2_miss", byp_r2, 64'h22);
    byp_rs1 = 5'd0;
    #1;
    chk("byp_r1_x0", byp_r1, 64'h11);
    byp_rs2 = 5'd3;
    #1;
    chk("byp_r2_hit", byp_r2, 64'h55);
    cyc();
    chk("byp_r2_nowr", byp_r2, 64'h22);
    byp_rs1 = '0; byp_rs2 = '0;
`endif

    // ---------------- randomized run against reference model ----------------
    do_reset();
    mq.delete();
    m_pend = '0; m_starve = 0; m_wr = 1'b0; m_d = '0; m_rd = '0;
    for (int t = 0; t < 600; t++) begin
      bit   m_stall;
      bit   m_ready;
      bit   nonempty;
      bit   alu_win;
      bit   popped;
      ent_t h;
      nonempty = (mq.size() > 0);
      m_stall  = (m_starve == STARVE_MAX) && nonempty;
      m_ready  = (mq.size() < DEPTH);
      chk("rnd_stall", {63'd0, stall}, {63'd0, m_stall});
      chk("rnd_ready", {63'd0, ext_ready}, {63'd0, m_ready});
      chk("rnd_pend", {32'd0, pend}, {32'd0, m_pend});
      chk("rnd_wr", {63'd0, wr}, {63'd0, m_wr});
      if (m_wr) chk("rnd_wdat", {rd, d[58:0]}, {m_rd, m_d[58:0]});
      if (m_wr) chk("rnd_dhi", {59'd0, d[63:59]}, {59'd0, m_d[63:59]});

      alu_wr    = ($urandom_range(0, 2) != 0) && !m_stall;
      alu_rd    = 5'($urandom_range(0, 15));
      alu_d     = {$urandom, $urandom};
      ext_valid = $urandom_range(0, 1) == 1;
      ext_rd    = 5'($urandom_range(0, 7));
      ext_d     = {$urandom, $urandom};
      iss_set   = $urandom_range(0, 2) == 0;
      iss_rd    = 5'($urandom_range(0, 7));

      alu_win = alu_wr && (alu_rd != 0) && !m_stall;
      popped  = nonempty && !alu_win;
      h = '{64'd0, 5'd0};
      if (popped) h = mq.pop_front();
      if (alu_win) begin
        m_wr = 1'b1; m_d = alu_d; m_rd = alu_rd;
      end else if (popped && h.r != 0) begin
        m_wr = 1'b1; m_d = h.dat; m_rd = h.r;
      end else begin
        m_wr = 1'b0;
      end
      if (popped) m_pend[h.r] = 1'b0;
      if (iss_set && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      m_pend[0] = 1'b0;
      if (!nonempty || popped) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
      if (ext_valid && m_ready) mq.push_back('{ext_d, ext_rd});
      cyc();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
